// File: rtl/fetch_unit_if.sv
// Decode-side and instruction-memory-side signals of the fetch front end.
// master: the fetch unit; slave: memory, execute and decode around it.
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] instr_pcplus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output instr_valid, instr, instr_pc, instr_pcplus4,
        input  instr_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  instr_valid, instr, instr_pc, instr_pcplus4,
        output instr_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, issues in-order memory requests
// under a credit limit so every response has a buffer slot, and flushes the
// buffer plus in-flight responses on a redirect from execute.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input logic        clk,
    input logic        rst,
    fetch_unit_if.master bus
);
    localparam int             PTR_W   = $clog2(FIFO_DEPTH);
    localparam int             CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [31:0]    NOP     = 32'h0000_0013;

    logic [31:0]      fetch_pc;
    logic [31:0]      rsp_pc;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] drop_cnt;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [31:0]      buf_instr [FIFO_DEPTH];
    logic [31:0]      buf_pc    [FIFO_DEPTH];

    logic             req_fire;
    logic             push;
    logic             pop;
    logic             head_valid;
    logic [CNT_W:0]   credit_used;
    logic [CNT_W-1:0] out_next;
    logic [31:0]      redirect_tgt;
    logic [31:0]      head_pc;

    // Credit check, handshakes and the post-update outstanding count.
    always_comb begin
        credit_used  = {1'b0, outstanding} + {1'b0, count};
        req_fire     = bus.imem_req_valid & bus.imem_req_ready;
        push         = bus.imem_rsp_valid & ~bus.redirect_valid & (drop_cnt == '0);
        head_valid   = (count != '0);
        pop          = head_valid & bus.instr_ready;
        out_next     = outstanding + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
        redirect_tgt = {bus.redirect_pc[31:2], 2'b00};
    end

    // Request side; rst gates valid so it drops the instant reset asserts.
    assign bus.imem_req_valid = rst & ~bus.redirect_valid & (credit_used < DEPTH_C);
    assign bus.imem_req_addr  = fetch_pc;

    // Head of the buffer toward decode; NOP and PC 0 while empty.
    always_comb begin
        head_pc           = head_valid ? buf_pc[rd_ptr] : 32'h0;
        bus.instr_valid   = head_valid;
        bus.instr         = head_valid ? buf_instr[rd_ptr] : NOP;
        bus.instr_pc      = head_pc;
        bus.instr_pcplus4 = head_pc + 32'd4;
    end

    // PC, credit and buffer bookkeeping; a redirect overrides everything else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            rsp_pc      <= RESET_PC;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            outstanding <= out_next;
            if (bus.redirect_valid) begin
                fetch_pc <= redirect_tgt;
                rsp_pc   <= redirect_tgt;
                drop_cnt <= out_next;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
            end else begin
                if (req_fire)
                    fetch_pc <= fetch_pc + 32'd4;
                if (bus.imem_rsp_valid) begin
                    if (drop_cnt != '0)
                        drop_cnt <= drop_cnt - CNT_W'(1);
                    else
                        rsp_pc <= rsp_pc + 32'd4;
                end
                if (push)
                    wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
            end
        end
    end

    // Buffer storage; contents are meaningless until count says otherwise.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= bus.imem_rsp_data;
            buf_pc[wr_ptr]    <= rsp_pc;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();
    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (.clk(clk), .rst(rst_n), .bus(bus));

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_hs = 0;
    int last_due = 0;
    int p_iready = 100, p_qready = 100, p_redir = 0, lat_min = 1, lat_max = 1;
    bit force_redir = 0;
    logic [31:0] force_tgt = '0;
    bit chk_flush = 0;
    bit saw_valid = 0;
    bit hold_valid = 0;
    logic [31:0] hold_pc, hold_instr;
    logic [31:0] exp_fetch;
    logic [31:0] sb[$];
    logic [31:0] mem_addr[$];
    int mem_due[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.instr_ready    = 1'b0;
    endtask

    task automatic restart_model();
        mem_addr.delete();
        mem_due.delete();
        last_due = cyc;
        sb.delete();
        sb.push_back(RST_PC);
        exp_fetch = RST_PC;
        hold_valid = 0;
        chk_flush = 0;
    endtask

    // Pull reset between clock edges, check outputs drop at once, release later.
    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_instr", bus.instr, NOP);
        restart_model();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    // One cycle of stimulus plus the memory model and request-side checks.
    task automatic drive_cycle();
        logic [31:0] tgt;
        int lat, due;
        @(negedge clk);
        cyc++;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (mem_addr.size() > 0 && mem_due[0] <= cyc) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = word_of(mem_addr.pop_front());
            mem_due.delete(0);
        end
        bus.redirect_valid = force_redir || ($urandom_range(99) < p_redir);
        bus.redirect_pc    = force_redir ? force_tgt : $urandom();
        force_redir        = 0;
        bus.instr_ready    = ($urandom_range(99) < p_iready);
        bus.imem_req_ready = ($urandom_range(99) < p_qready);
        #1;
        saw_valid = bus.instr_valid;
        if (chk_flush) begin
            check("flush_after_redirect", 32'(bus.instr_valid), 32'd0);
            chk_flush = 0;
        end
        if (bus.redirect_valid)
            check("req_on_redirect", 32'(bus.imem_req_valid), 32'd0);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            check("req_addr", bus.imem_req_addr, exp_fetch);
            exp_fetch += 32'd4;
            n_acc++;
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_addr.push_back(bus.imem_req_addr);
            mem_due.push_back(due);
        end
        @(posedge clk);
        if (bus.redirect_valid) begin
            tgt = {bus.redirect_pc[31:2], 2'b00};
            exp_fetch = tgt;
            sb.delete();
            sb.push_back(tgt);
            chk_flush = 1;
            hold_valid = 0;
        end
    endtask

    // Monitor: compares every decode handshake against the scoreboard head.
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold_valid = 0;
                continue;
            end
            if (hold_valid) begin
                check("hold_valid", 32'(bus.instr_valid), 32'd1);
                check("hold_pc", bus.instr_pc, hold_pc);
                check("hold_instr", bus.instr, hold_instr);
            end
            hold_valid = 0;
            if (bus.instr_valid) begin
                if (bus.instr_ready) begin
                    n_hs++;
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_empty: got pc %h expected no instruction", bus.instr_pc);
                    end else begin
                        exp_pc = sb.pop_front();
                        check("instr_pc", bus.instr_pc, exp_pc);
                        check("instr", bus.instr, word_of(exp_pc));
                        check("instr_pcplus4", bus.instr_pcplus4, exp_pc + 32'd4);
                        sb.push_back(exp_pc + 32'd4);
                    end
                end else begin
                    hold_valid = 1;
                    hold_pc    = bus.instr_pc;
                    hold_instr = bus.instr;
                end
            end else begin
                check("idle_instr_nop", bus.instr, NOP);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int first_valid;
        idle_inputs();
        restart_model();
        #3;
        check("reset_instr_valid", 32'(bus.instr_valid), 32'd0);
        check("reset_instr", bus.instr, NOP);
        check("reset_instr_pc", bus.instr_pc, 32'd0);
        check("reset_req_valid", 32'(bus.imem_req_valid), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Free-flowing stream through the address wrap; fill latency of 3.
        first_valid = 0;
        for (int i = 1; i <= 20; i++) begin
            drive_cycle();
            if (saw_valid && first_valid == 0) first_valid = i;
        end
        check("fill_latency", 32'(first_valid), 32'd3);

        // Mid-stream reset, then decode stalled: only FIFO_DEPTH requests go out.
        do_reset();
        p_iready = 0;
        n_acc = 0;
        repeat (10) drive_cycle();
        check("stall_req_count", 32'(n_acc), 32'd2);
        check("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check("stall_head_pc", bus.instr_pc, RST_PC);
        p_iready = 100;
        repeat (10) drive_cycle();

        // Redirect to 0x102 with two requests in flight.
        do_reset();
        p_iready = 0;
        lat_min = 4;
        lat_max = 4;
        repeat (2) drive_cycle();
        force_redir = 1;
        force_tgt = 32'h0000_0102;
        drive_cycle();
        check("redirect_fetch_pc", exp_fetch, 32'h0000_0100);
        p_iready = 100;
        lat_min = 1;
        lat_max = 1;
        n_hs = 0;
        repeat (12) drive_cycle();
        check("post_redirect_progress", 32'(n_hs > 0), 32'd1);

        // Randomised traffic with redirects colliding with responses/handshakes.
        p_iready = 70;
        p_qready = 70;
        p_redir  = 5;
        lat_min  = 1;
        lat_max  = 4;
        n_hs = 0;
        repeat (3000) drive_cycle();
        do_reset();
        repeat (1000) drive_cycle();
        check("random_progress", 32'(n_hs > 200), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
